// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_port_arbiter_pkg;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  // Default watchdog limit in cycles.
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above the pointer, with wrap.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant_c,
  output logic [IDX_W-1:0] o_idx_c,
  output logic             o_valid_c
);

  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_cand;

  // Walk the channels from the pointer upward and keep the first hit.
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_cand = w_sum[IDX_W-1:0];
      if (!o_valid_c && i_req[w_cand]) begin
        o_valid_c         = 1'b1;
        o_idx_c           = w_cand;
        o_grant_c[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port among NUM_MASTERS requesters; one outstanding access, round-robin.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            m_ren,
  input  logic [NUM_MASTERS-1:0]            m_wen,
  input  logic [NUM_MASTERS*ADDR_W-1:0]     m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_bsel,
  output logic [NUM_MASTERS-1:0]            m_ready,
  output logic                              m_err,
  output logic [DATA_W-1:0]                 m_rdata,
  output logic                              mem_ren,
  output logic                              mem_wen,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [DATA_W-1:0]                 mem_wdata,
  output logic [(DATA_W/8)-1:0]             mem_bsel,
  input  logic                              mem_ready,
  input  logic [DATA_W-1:0]                 mem_rdata
);

  localparam int unsigned BSEL_W = DATA_W / 8;
  localparam int unsigned IDX_W  = idx_width(NUM_MASTERS);

  arb_state_e r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]       r_grant, w_grant_nxt;
  logic                   r_mem_ren, w_mem_ren_nxt;
  logic                   r_mem_wen, w_mem_wen_nxt;
  logic [ADDR_W-1:0]      r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0]      r_mem_wdata, w_mem_wdata_nxt;
  logic [BSEL_W-1:0]      r_mem_bsel, w_mem_bsel_nxt;
  logic [NUM_MASTERS-1:0] r_m_ready, w_m_ready_nxt;
  logic                   r_m_err, w_m_err_nxt;
  logic [DATA_W-1:0]      r_m_rdata, w_m_rdata_nxt;

  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_arb_grant;
  logic [IDX_W-1:0]       w_arb_idx;
  logic                   w_arb_valid;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic [BSEL_W-1:0]      w_sel_bsel;
  logic                   w_sel_ren;
  logic                   w_sel_wen;
  logic                   w_timeout;

  assign w_req = m_ren | m_wen;

  rr_arbiter #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req     (w_req),
    .i_ptr     (r_ptr),
    .o_grant_c (w_arb_grant),
    .o_idx_c   (w_arb_idx),
    .o_valid_c (w_arb_valid)
  );

  // Select the winning channel's request payload.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_bsel  = '0;
    w_sel_ren   = 1'b0;
    w_sel_wen   = 1'b0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (w_arb_grant[i]) begin
        w_sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = m_wdata[i*DATA_W +: DATA_W];
        w_sel_bsel  = m_bsel[i*BSEL_W +: BSEL_W];
        w_sel_ren   = m_ren[i];
        w_sel_wen   = m_wen[i];
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  // Count BUSY cycles; held at zero elsewhere so each access starts fresh.
  always_comb begin
    w_cnt_nxt = '0;
    if (r_state == ARB_BUSY) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  // Without the watchdog BUSY waits for mem_ready indefinitely.
  localparam logic TIMEOUT_ANY = (TIMEOUT_CYCLES != 0);
  assign w_timeout = 1'b0 & TIMEOUT_ANY;
`endif

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_grant_nxt     = r_grant;
    w_mem_ren_nxt   = r_mem_ren;
    w_mem_wen_nxt   = r_mem_wen;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_mem_bsel_nxt  = r_mem_bsel;
    w_m_rdata_nxt   = r_m_rdata;
    w_m_ready_nxt   = '0;
    w_m_err_nxt     = 1'b0;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_arb_valid) begin
          w_grant_nxt     = w_arb_idx;
          w_mem_addr_nxt  = w_sel_addr;
          w_mem_wdata_nxt = w_sel_wdata;
          w_mem_bsel_nxt  = w_sel_bsel;
          // A request with both ren and wen is issued as a write.
          w_mem_wen_nxt   = w_sel_wen;
          w_mem_ren_nxt   = w_sel_ren & ~w_sel_wen;
          w_state_nxt     = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (mem_ready) begin
          w_m_rdata_nxt          = mem_rdata;
          w_mem_ren_nxt          = 1'b0;
          w_mem_wen_nxt          = 1'b0;
          w_m_ready_nxt[r_grant] = 1'b1;
          w_state_nxt            = ARB_DONE;
        end else if (w_timeout) begin
          w_m_rdata_nxt          = '0;
          w_mem_ren_nxt          = 1'b0;
          w_mem_wen_nxt          = 1'b0;
          w_m_ready_nxt[r_grant] = 1'b1;
          w_m_err_nxt            = 1'b1;
          w_state_nxt            = ARB_DONE;
        end
      end
      ARB_DONE: begin
        if (r_grant == IDX_W'(NUM_MASTERS - 1)) begin
          w_ptr_nxt = '0;
        end else begin
          w_ptr_nxt = r_grant + IDX_W'(1);
        end
        w_state_nxt = ARB_IDLE;
      end
      default: begin
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_mem_ren   <= 1'b0;
      r_mem_wen   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_bsel  <= '0;
      r_m_ready   <= '0;
      r_m_err     <= 1'b0;
      r_m_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_grant     <= w_grant_nxt;
      r_mem_ren   <= w_mem_ren_nxt;
      r_mem_wen   <= w_mem_wen_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_mem_bsel  <= w_mem_bsel_nxt;
      r_m_ready   <= w_m_ready_nxt;
      r_m_err     <= w_m_err_nxt;
      r_m_rdata   <= w_m_rdata_nxt;
    end
  end

  assign m_ready   = r_m_ready;
  assign m_err     = r_m_err;
  assign m_rdata   = r_m_rdata;
  assign mem_ren   = r_mem_ren;
  assign mem_wen   = r_mem_wen;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_bsel  = r_mem_bsel;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: two masters, memory responder, response monitor.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  bsel;
  } mem_exp_t;

  typedef struct packed {
    logic [1:0]  ready;
    logic        chk;
    logic [31:0] rdata;
    logic        err;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  m_ren = '0;
  logic [1:0]  m_wen = '0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  logic [7:0]  m_bsel = '0;
  logic [1:0]  m_ready;
  logic        m_err;
  logic [31:0] m_rdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_bsel;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  bit resp_en = 1'b1;
  int mem_wait = 0;

  mem_exp_t  exp_mem[$];
  resp_exp_t exp_resp[$];

  mem_port_arbiter #(
    .NUM_MASTERS    (2),
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .m_ren     (m_ren),
    .m_wen     (m_wen),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_bsel    (m_bsel),
    .m_ready   (m_ready),
    .m_err     (m_err),
    .m_rdata   (m_rdata),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_bsel  (mem_bsel),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEAD_BEEF;
      32'h0000_0104: return 32'hCAFE_F00D;
      32'h0000_0300: return 32'h0BAD_F00D;
      32'h0000_0304: return 32'h600D_CAFE;
      32'h0000_0308: return 32'h1111_2222;
      32'h0000_030C: return 32'h3333_4444;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory responder: accepts a held strobe after mem_wait cycles and checks the latched request.
  initial begin
    int wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready) begin
        mem_ready = 1'b0;
      end else if (resp_en && (mem_ren || mem_wen)) begin
        if (wait_cnt == mem_wait) begin
          mem_exp_t e;
          wait_cnt  = 0;
          mem_ready = 1'b1;
          mem_rdata = mem_model(mem_addr);
          checks++;
          if (exp_mem.size() == 0) begin
            failures++;
            $display("FAIL mem_unexpected actual=%0h required=none",
                     {mem_ren, mem_wen, mem_addr, mem_wdata, mem_bsel});
          end else begin
            e = exp_mem.pop_front();
            if ({mem_ren, mem_wen, mem_addr, mem_wdata, mem_bsel} !== e) begin
              failures++;
              $display("FAIL mem_req actual=%0h required=%0h",
                       {mem_ren, mem_wen, mem_addr, mem_wdata, mem_bsel}, e);
            end
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // Response monitor: every m_ready pulse is matched against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (m_ready != 2'b00) begin
        resp_exp_t e;
        checks++;
        if (exp_resp.size() == 0) begin
          failures++;
          $display("FAIL resp_unexpected actual=%0h required=none", {m_ready, m_err, m_rdata});
        end else begin
          e = exp_resp.pop_front();
          if (m_ready !== e.ready || m_err !== e.err || (e.chk && m_rdata !== e.rdata)) begin
            failures++;
            $display("FAIL resp ready=%0b err=%0b rdata=%0h required ready=%0b err=%0b rdata=%0h",
                     m_ready, m_err, m_rdata, e.ready, e.err, e.rdata);
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] rdy, input logic ren, input logic wen,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] bsel,
                      input logic chk, input logic [31:0] rdata, input logic err, input bit mem_side);
    if (mem_side) exp_mem.push_back('{ren: ren, wen: wen, addr: addr, wdata: wdata, bsel: bsel});
    exp_resp.push_back('{ready: rdy, chk: chk, rdata: rdata, err: err});
  endtask

  // Issue one request and hold it until this master's m_ready; lat = cycles to m_ready.
  task automatic do_access(input int m, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] bsel, output int lat);
    bit got = 1'b0;
    @(posedge clk); #1;
    m_ren[m] = ren;
    m_wen[m] = wen;
    m_addr[m*32 +: 32]  = addr;
    m_wdata[m*32 +: 32] = wdata;
    m_bsel[m*4 +: 4]    = bsel;
    lat = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (m_ready[m]) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wait_ready master=%0d actual=none required=pulse", m);
    end
    @(posedge clk); #1;
    m_ren[m] = 1'b0;
    m_wen[m] = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=hung required=finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int lat;
    int lat_b;
    bit seen;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_m_ready", 128'(m_ready), 128'(0));
    check("rst_m_err",   128'(m_err),   128'(0));
    check("rst_m_rdata", 128'(m_rdata), 128'(0));
    check("rst_strobes", 128'({mem_ren, mem_wen}), 128'(0));
    check("rst_mem_addr", 128'(mem_addr), 128'(0));
    reset = 1'b1;

    // Single zero-wait read from master 0.
    push(2'b01, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    do_access(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, lat);
    check("lat_zero_wait", 128'(lat), 128'(2));

    // Write from master 1.
    push(2'b10, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011, 1'b0, 32'h0, 1'b0, 1'b1);
    do_access(1, 1'b0, 1'b1, 32'h200, 32'h12345678, 4'b0011, lat);
    check("lat_write", 128'(lat), 128'(2));

    // Two rounds of simultaneous requests: grant order 0,1,0,1.
    push(2'b01, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    push(2'b10, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF, 1'b1, 32'h600DCAFE, 1'b0, 1'b1);
    fork
      do_access(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, lat);
      do_access(1, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF, lat_b);
    join
    check("rr_r1_lat_m1", 128'(lat_b), 128'(5));
    push(2'b01, 1'b1, 1'b0, 32'h308, 32'h0, 4'hF, 1'b1, 32'h11112222, 1'b0, 1'b1);
    push(2'b10, 1'b1, 1'b0, 32'h30C, 32'h0, 4'hF, 1'b1, 32'h33334444, 1'b0, 1'b1);
    fork
      do_access(0, 1'b1, 1'b0, 32'h308, 32'h0, 4'hF, lat);
      do_access(1, 1'b1, 1'b0, 32'h30C, 32'h0, 4'hF, lat_b);
    join
    check("rr_r2_lat_m0", 128'(lat), 128'(2));

    // ren+wen together is a write.
    push(2'b01, 1'b0, 1'b1, 32'h400, 32'hA5A55A5A, 4'hC, 1'b0, 32'h0, 1'b0, 1'b1);
    do_access(0, 1'b1, 1'b1, 32'h400, 32'hA5A55A5A, 4'hC, lat);

    // Wait states on the memory side.
    mem_wait = 3;
    push(2'b10, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    do_access(1, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, lat);
    check("lat_wait3", 128'(lat), 128'(5));
    mem_wait = 0;

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: watchdog completes with error.
    resp_en = 1'b0;
    push(2'b10, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF, 1'b1, 32'h0, 1'b1, 1'b0);
    do_access(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF, lat);
    check("lat_timeout", 128'(lat), 128'(10));
    check("timeout_strobes", 128'({mem_ren, mem_wen}), 128'(0));
    resp_en = 1'b1;
`else
    // Long stall without watchdog: no error, data delivered.
    mem_wait = 20;
    push(2'b01, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1);
    do_access(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF, lat);
    check("lat_long_stall", 128'(lat), 128'(22));
    mem_wait = 0;
`endif

    // Move the pointer to 1, then reset in the middle of an access.
    push(2'b01, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, 1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
    do_access(0, 1'b1, 1'b0, 32'h104, 32'h0, 4'hF, lat);
    resp_en = 1'b0;
    @(posedge clk); #1;
    m_ren[0] = 1'b1;
    m_addr[31:0] = 32'h100;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (mem_ren) seen = 1'b1;
    end
    check("busy_strobe_seen", 128'(seen), 128'(1));
    reset = 1'b0;
    #1;
    check("rst_busy_strobes", 128'({mem_ren, mem_wen}), 128'(0));
    check("rst_busy_ready",   128'(m_ready), 128'(0));
    check("rst_busy_addr",    128'(mem_addr), 128'(0));
    m_ren = '0;
    repeat (2) @(negedge clk);
    check("rst_busy_ready_hold", 128'(m_ready), 128'(0));
    reset = 1'b1;
    resp_en = 1'b1;

    // After reset, simultaneous requests start again from master 0.
    push(2'b01, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, 1'b1, 32'h0BADF00D, 1'b0, 1'b1);
    push(2'b10, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF, 1'b1, 32'h600DCAFE, 1'b0, 1'b1);
    fork
      do_access(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF, lat);
      do_access(1, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF, lat_b);
    join
    check("post_rst_lat_m0", 128'(lat), 128'(2));

    repeat (5) @(negedge clk);
    check("mem_queue_empty",  128'(exp_mem.size()),  128'(0));
    check("resp_queue_empty", 128'(exp_resp.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
